// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: instruction classes, ALU functions, major opcodes
// and the opcode classification helpers used by the decode stage.
package cpu_pkg;

  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE
  } instruction_type_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_function_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  function automatic logic opcode_known(input logic [6:0] opcode);
    case (opcode)
      OPCODE_OP, OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR, OPCODE_SYSTEM, OPCODE_STORE,
      OPCODE_BRANCH, OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: opcode_known = 1'b1;
      default:                                             opcode_known = 1'b0;
    endcase
  endfunction

  // Unknown opcodes fall into I_TYPE so they decode as a NOP-shaped instruction.
  function automatic instruction_type_t opcode_to_type(input logic [6:0] opcode);
    case (opcode)
      OPCODE_OP:                   opcode_to_type = R_TYPE;
      OPCODE_STORE:                opcode_to_type = S_TYPE;
      OPCODE_BRANCH:               opcode_to_type = B_TYPE;
      OPCODE_LUI, OPCODE_AUIPC:    opcode_to_type = U_TYPE;
      OPCODE_JAL:                  opcode_to_type = J_TYPE;
      default:                     opcode_to_type = I_TYPE;
    endcase
  endfunction

endpackage

// File: rtl/immediate_gen.sv
// Combinational RV32I immediate extraction; sign-extends I/S/B/J from bit 31 to XLEN.
module immediate_gen
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]        instr_i,
  input  instruction_type_t  instruction_type_i,
  output logic [XLEN-1:0]    imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instruction_type_i)
      I_TYPE:  imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      S_TYPE:  imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      B_TYPE:  imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      U_TYPE:  imm32 = {instr_i[31:12], 12'b0};
      J_TYPE:  imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Single-entry RV32I decode pipeline stage with valid/ready handshake and flush.
// Optional DECODE_ILLEGAL_TRAP_EN adds a registered out_illegal flag for unknown opcodes.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instruction,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output instruction_type_t out_instruction_type,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic              out_illegal,
`endif
  output logic [XLEN-1:0]   out_imm
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    instruction_type_t itype;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [XLEN-1:0]   imm;
  } payload_t;

  localparam payload_t PayloadReset = '{
    pc: '0, itype: I_TYPE, opcode: '0, funct3: '0, funct7: '0,
    rd: '0, rs1: '0, rs2: '0, imm: '0
  };

  logic              known;
  instruction_type_t dec_type;
  logic [XLEN-1:0]   gen_imm;
  payload_t          dec_payload;
  payload_t          payload_d, payload_q;
  logic              valid_d, valid_q;
  logic              in_fire;

  assign known    = opcode_known(in_instruction[6:0]);
  assign dec_type = known ? opcode_to_type(in_instruction[6:0]) : I_TYPE;

  immediate_gen #(
    .XLEN (XLEN)
  ) u_immediate_gen (
    .instr_i            (in_instruction[31:7]),
    .instruction_type_i (dec_type),
    .imm_o              (gen_imm)
  );

  always_comb begin
    dec_payload        = PayloadReset;
    dec_payload.pc     = in_pc;
    dec_payload.itype  = dec_type;
    dec_payload.opcode = in_instruction[6:0];
    if (known) begin
      dec_payload.imm = gen_imm;
      if (!(dec_type inside {S_TYPE, B_TYPE})) dec_payload.rd = in_instruction[11:7];
      if (!(dec_type inside {U_TYPE, J_TYPE})) begin
        dec_payload.rs1    = in_instruction[19:15];
        dec_payload.funct3 = in_instruction[14:12];
      end
      if (dec_type inside {R_TYPE, S_TYPE, B_TYPE}) dec_payload.rs2 = in_instruction[24:20];
      if (dec_type inside {R_TYPE, I_TYPE}) dec_payload.funct7 = in_instruction[31:25];
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_fire) begin
      valid_d   = 1'b1;
      payload_d = dec_payload;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= PayloadReset;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_d, illegal_q;

  always_comb begin
    illegal_d = illegal_q;
    if (flush) begin
      illegal_d = 1'b0;
    end else if (in_fire) begin
      illegal_d = !known;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign out_illegal = illegal_q;
`endif

  assign out_valid            = valid_q;
  assign out_pc               = payload_q.pc;
  assign out_instruction_type = payload_q.itype;
  assign out_opcode           = payload_q.opcode;
  assign out_funct3           = payload_q.funct3;
  assign out_funct7           = payload_q.funct7;
  assign out_rd               = payload_q.rd;
  assign out_rs1              = payload_q.rs1;
  assign out_rs2              = payload_q.rs2;
  assign out_imm              = payload_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed RV32I cases plus randomized traffic
// against a field-arithmetic reference decoder.
module tb_decode_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  itype;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       in_instruction, in_pc, out_pc, out_imm;
  instruction_type_t out_instruction_type;
  logic [6:0]        out_opcode, out_funct7;
  logic [2:0]        out_funct3;
  logic [4:0]        out_rd, out_rs1, out_rs2;
  logic              act_illegal;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN (32)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_instruction       (in_instruction),
    .in_pc                (in_pc),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_pc               (out_pc),
    .out_instruction_type (out_instruction_type),
    .out_opcode           (out_opcode),
    .out_funct3           (out_funct3),
    .out_funct7           (out_funct7),
    .out_rd               (out_rd),
    .out_rs1              (out_rs1),
    .out_rs2              (out_rs2),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .out_illegal          (act_illegal),
`endif
    .out_imm              (out_imm)
  );

`ifndef DECODE_ILLEGAL_TRAP_EN
  assign act_illegal = 1'b0;
`endif

  // Reference decoder: immediates rebuilt as signed integers from the format bit positions.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   s;
    bit   known;
    instruction_type_t t;
    e = '0;
    e.pc = pc;
    e.opcode = ins[6:0];
    known = 1;
    t = I_TYPE;
    case (ins[6:0])
      7'h33:                      t = R_TYPE;
      7'h13, 7'h03, 7'h67, 7'h73: t = I_TYPE;
      7'h23:                      t = S_TYPE;
      7'h63:                      t = B_TYPE;
      7'h37, 7'h17:               t = U_TYPE;
      7'h6F:                      t = J_TYPE;
      default:                    known = 0;
    endcase
    e.itype = t;
    if (known) begin
      e.rd     = (t == S_TYPE || t == B_TYPE) ? 5'd0 : ins[11:7];
      e.rs1    = (t == U_TYPE || t == J_TYPE) ? 5'd0 : ins[19:15];
      e.rs2    = (t == I_TYPE || t == U_TYPE || t == J_TYPE) ? 5'd0 : ins[24:20];
      e.funct3 = (t == U_TYPE || t == J_TYPE) ? 3'd0 : ins[14:12];
      e.funct7 = (t == R_TYPE || t == I_TYPE) ? ins[31:25] : 7'd0;
      s = 0;
      case (t)
        I_TYPE: begin
          s = int'(ins[31:20]);
          if (s >= 2048) s -= 4096;
        end
        S_TYPE: begin
          s = int'(ins[31:25]) * 32 + int'(ins[11:7]);
          if (s >= 2048) s -= 4096;
        end
        B_TYPE: begin
          s = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
              int'(ins[11:8]) * 2;
          if (ins[31]) s -= 8192;
        end
        J_TYPE: begin
          s = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12) +
              int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
          if (ins[31]) s -= (1 << 21);
        end
        U_TYPE: s = int'(ins[31:12]) * 4096;
        default: s = 0;
      endcase
      e.imm = 32'(s);
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    e.illegal = !known;
`endif
    return e;
  endfunction

  function automatic exp_t dut_payload();
    exp_t a;
    a.pc = out_pc;
    a.itype = out_instruction_type;
    a.opcode = out_opcode;
    a.funct3 = out_funct3;
    a.funct7 = out_funct7;
    a.rd = out_rd;
    a.rs1 = out_rs1;
    a.rs2 = out_rs2;
    a.imm = out_imm;
    a.illegal = act_illegal;
    return a;
  endfunction

  function automatic void report(input string name, input exp_t a, input exp_t e);
    $display("FAIL %s: got pc=%h type=%0d op=%h f3=%h f7=%h rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b; want pc=%h type=%0d op=%h f3=%h f7=%h rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b",
             name, a.pc, a.itype, a.opcode, a.funct3, a.funct7, a.rd, a.rs1, a.rs2, a.imm,
             a.illegal, e.pc, e.itype, e.opcode, e.funct3, e.funct7, e.rd, e.rs1, e.rs2,
             e.imm, e.illegal);
  endfunction

  // Monitor: the model holds at most one entry; out_valid must track its occupancy.
  always @(negedge clk) begin
    exp_t a;
    checks++;
    if (out_valid !== (sb.size() != 0)) begin
      failures++;
      $display("FAIL out_valid: got %b want %b at %0t", out_valid, sb.size() != 0, $time);
    end
    checks++;
    if (in_ready !== ((sb.size() == 0) || out_ready)) begin
      failures++;
      $display("FAIL in_ready: got %b want %b at %0t", in_ready,
               (sb.size() == 0) || out_ready, $time);
    end
    if (out_valid === 1'b1 && sb.size() != 0) begin
      a = dut_payload();
      checks++;
      if (a !== sb[0]) begin
        failures++;
        report("payload", a, sb[0]);
      end
      if (out_ready) void'(sb.pop_front());
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic r);
    in_valid = v;
    in_instruction = ins;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    rst = r;
    @(negedge clk);
    #1;
    if (r || fl) sb.delete();
    else if (v && in_ready) sb.push_back(ref_decode(ins, pc));
    @(posedge clk);
    #1;
  endtask

  logic [6:0] op_table [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6F};

  initial begin
    exp_t rv, a;
    logic [31:0] ins, pc;
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    rv = '0;
    rv.itype = I_TYPE;
    a = dut_payload();
    checks++;
    if (a !== rv) begin
      failures++;
      report("reset_values", a, rv);
    end

    drive(1, 32'h002081B3, 32'h100, 1, 0, 0);  // add
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    drive(1, 32'h402081B3, 32'h104, 1, 0, 0);  // sub
    drive(1, 32'hFE208EE3, 32'h108, 1, 0, 0);  // beq -4
    drive(1, 32'h123452B7, 32'h10C, 1, 0, 0);  // lui
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    drive(1, 32'hFFF00093, 32'h110, 0, 0, 0);  // addi -1, then stall
    for (int i = 0; i < 3; i++) drive(0, 32'h0, 32'h0, 0, 0, 0);
    drive(1, 32'h0020A423, 32'h114, 1, 0, 0);  // sw on the ready-rise cycle
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    drive(1, 32'h00000013, 32'h118, 0, 0, 0);
    drive(1, 32'h00100093, 32'h11C, 0, 1, 0);  // flush while held, in_ready low
    drive(1, 32'h00000013, 32'h120, 1, 0, 0);
    drive(1, 32'h00200113, 32'h124, 1, 1, 0);  // flush while held, in_ready high
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    drive(1, 32'hFFFFFFFF, 32'h128, 1, 0, 0);  // opcode 0x7F
    drive(1, 32'h0000007F, 32'h12C, 1, 0, 0);
    drive(1, 32'h00300193, 32'h130, 0, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    drive(1, 32'h00400213, 32'h134, 0, 0, 1);  // rst mid-stall
    drive(0, 32'h0, 32'h0, 1, 0, 0);

    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 9))
        0:       ins[6:0] = 7'h7F;
        1:       ins[6:0] = 7'($urandom);
        default: ins[6:0] = op_table[$urandom_range(0, 9)];
      endcase
      drive($urandom_range(0, 3) != 0, ins, pc, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      pc += 4;
    end
    for (int i = 0; i < 3; i++) drive(0, 32'h0, 32'h0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
